// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: frame geometry and one-hot FSM encoding
// shared by the ADC SPI controller and its SCLK generator.
package adc_spi_pkg;

  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_DATA_BITS  = 12;
  localparam int ADC_LEAD_BITS  = 4;

  localparam int S_IDLE  = 0;
  localparam int S_SETUP = 1;
  localparam int S_SHIFT = 2;
  localparam int S_QUIET = 3;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_SETUP = 4'b0010,
    ST_SHIFT = 4'b0100,
    ST_QUIET = 4'b1000
  } state_t;

endpackage

// File: rtl/adc_sclk_gen.sv
// adc_sclk_gen: divides clk into one setup half-period plus
// 16 SCLK periods, with fall/rise/done strobes for the FSM.
module adc_sclk_gen
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  output logic o_sclk,
  output logic o_fall,
  output logic o_rise,
  output logic o_done
);

  localparam logic [3:0] CNT_LAST =
    4'(CLK_DIV - 1);
  localparam logic [5:0] HALF_LAST =
    6'(2 * ADC_FRAME_BITS);

  logic [3:0] r_cnt;
  logic [5:0] r_half;
  logic       r_active;
  logic       r_sclk;

  logic w_wrap;
  logic w_last;

  assign w_wrap = r_active & (r_cnt == CNT_LAST);
  assign w_last = (r_half == HALF_LAST);

  // Half 0 is the cs_n setup time; even halves end
  // in a falling edge, odd halves in a rising edge.
  assign o_fall = w_wrap & ~w_last & ~r_half[0];
  assign o_rise = w_wrap & ~w_last & r_half[0];
  assign o_done = w_wrap & w_last;
  assign o_sclk = r_sclk;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_half   <= '0;
      r_active <= 1'b0;
      r_sclk   <= 1'b1;
    end else if (i_start) begin
      r_cnt    <= '0;
      r_half   <= '0;
      r_active <= 1'b1;
      r_sclk   <= 1'b1;
    end else if (w_wrap) begin
      r_cnt <= '0;
      if (w_last) begin
        r_active <= 1'b0;
        r_sclk   <= 1'b1;
      end else begin
        r_half <= r_half + 6'd1;
        r_sclk <= ~r_sclk;
      end
    end else if (r_active) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/adc_spi_ctrl.sv
// adc_spi_ctrl: turns each request edge into one 16-clock
// SPI read of a 12-bit ADC and returns it with a ready level.
module adc_spi_ctrl
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int QUIET_CYCLES = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     adc_data_req_i,
  output logic                     adc_data_rdy_o,
  output logic [ADC_DATA_BITS-1:0] adc_data_o,
  output logic                     frame_err_o,
  output logic                     spi_cs_n_o,
  output logic                     spi_sclk_o,
  input  logic                     spi_miso_i
);

  localparam logic [3:0] Q_LAST =
    4'(QUIET_CYCLES - 1);

  state_t                    r_state;
  logic                      r_req_d1;
  logic                      r_miso;
  logic                      r_pend;
  logic                      r_rdy;
  logic                      r_err;
  logic                      r_cs_n;
  logic [ADC_DATA_BITS-1:0]  r_data;
  logic [ADC_FRAME_BITS-1:0] r_shift;
  logic [3:0]                r_qcnt;

  logic w_edge;
  logic w_start;
  logic w_fall;
  logic w_rise;
  logic w_done;

  assign w_edge  = adc_data_req_i & ~r_req_d1;
  assign w_start = r_state[S_IDLE]
                 & (w_edge | r_pend);

  adc_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk (
    .i_clk   (clk_i),
    .i_rst_n (reset_n_i),
    .i_start (w_start),
    .o_sclk  (spi_sclk_o),
    .o_fall  (w_fall),
    .o_rise  (w_rise),
    .o_done  (w_done)
  );

  // Left running through reset so a request that rises
  // while reset is asserted does not fire afterwards.
  always_ff @(posedge clk_i) begin
    r_req_d1 <= adc_data_req_i;
    r_miso   <= spi_miso_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
      r_pend  <= 1'b0;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
      r_cs_n  <= 1'b1;
      r_data  <= '0;
      r_shift <= '0;
      r_qcnt  <= '0;
    end else begin
      unique case (1'b1)
        r_state[S_IDLE]: begin
          if (w_start) begin
            r_state <= ST_SETUP;
            r_cs_n  <= 1'b0;
            r_rdy   <= 1'b0;
            r_pend  <= 1'b0;
            r_shift <= '0;
            r_qcnt  <= '0;
          end
        end
        r_state[S_SETUP]: begin
          if (w_fall) r_state <= ST_SHIFT;
        end
        r_state[S_SHIFT]: begin
          if (w_rise) begin
            r_shift <= {r_shift[ADC_FRAME_BITS-2:0],
                        r_miso};
          end
          if (w_done) begin
            r_data  <= r_shift[ADC_DATA_BITS-1:0];
            r_err   <= |r_shift[ADC_FRAME_BITS-1 -:
                                ADC_LEAD_BITS];
            r_rdy   <= 1'b1;
            r_cs_n  <= 1'b1;
            r_qcnt  <= '0;
            r_state <= ST_QUIET;
          end
        end
        r_state[S_QUIET]: begin
          if (w_edge) r_pend <= 1'b1;
          if (r_qcnt == Q_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_qcnt <= r_qcnt + 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign adc_data_rdy_o = r_rdy;
  assign adc_data_o     = r_data;
  assign frame_err_o    = r_err;
  assign spi_cs_n_o     = r_cs_n;

endmodule

// File: tb/tb_adc_spi_ctrl.sv
// tb_adc_spi_ctrl: ADC serial models plus a scoreboard for
// two controllers (CLK_DIV=2 and CLK_DIV=3).
module tb_adc_spi_ctrl;

  localparam int QC = 4;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        req   [2];
  logic        rdy   [2];
  logic [11:0] data  [2];
  logic        err   [2];
  logic        cs    [2];
  logic        sclk  [2];
  logic        miso  [2];

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] adc0 [$];
  logic [15:0] adc1 [$];
  logic [12:0] sb0 [$];
  logic [12:0] sb1 [$];

  int          idx      [2];
  int          falls    [2];
  int          cs_falls [2];
  logic [15:0] cur      [2];
  logic        p_cs     [2];
  logic        p_sclk   [2];
  logic        p_rdy    [2];

  always #5 clk = ~clk;

  adc_spi_ctrl #(.CLK_DIV(2), .QUIET_CYCLES(QC)) dut (
    .clk_i          (clk),
    .reset_n_i      (rst_n[0]),
    .adc_data_req_i (req[0]),
    .adc_data_rdy_o (rdy[0]),
    .adc_data_o     (data[0]),
    .frame_err_o    (err[0]),
    .spi_cs_n_o     (cs[0]),
    .spi_sclk_o     (sclk[0]),
    .spi_miso_i     (miso[0])
  );

  adc_spi_ctrl #(.CLK_DIV(3), .QUIET_CYCLES(QC)) dut3 (
    .clk_i          (clk),
    .reset_n_i      (rst_n[1]),
    .adc_data_req_i (req[1]),
    .adc_data_rdy_o (rdy[1]),
    .adc_data_o     (data[1]),
    .frame_err_o    (err[1]),
    .spi_cs_n_o     (cs[1]),
    .spi_sclk_o     (sclk[1]),
    .spi_miso_i     (miso[1])
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // ADC: MSB launched on the first SCLK fall after cs_n fall.
  initial begin
    for (int u = 0; u < 2; u++) begin
      idx[u] = 0; falls[u] = 0; cs_falls[u] = 0;
      cur[u] = '0; p_cs[u] = 1'b1; p_sclk[u] = 1'b1;
      miso[u] = 1'b0;
    end
  end

  always @(cs[0] or sclk[0] or cs[1] or sclk[1]) begin
    for (int u = 0; u < 2; u++) begin
      if (p_cs[u] === 1'b1 && cs[u] === 1'b0) begin
        idx[u] = 15;
        falls[u] = 0;
        cs_falls[u]++;
        cur[u] = '0;
        if (u == 0 && adc0.size() != 0)
          cur[u] = adc0.pop_front();
        if (u == 1 && adc1.size() != 0)
          cur[u] = adc1.pop_front();
      end else if (cs[u] === 1'b0 && p_sclk[u] === 1'b1
                   && sclk[u] === 1'b0) begin
        falls[u]++;
        if (idx[u] >= 0) begin
          miso[u] = cur[u][idx[u]];
          idx[u]--;
        end
      end
      p_cs[u] = cs[u];
      p_sclk[u] = sclk[u];
    end
  end

  always @(posedge clk) begin
    logic [12:0] e;
    #1;
    for (int u = 0; u < 2; u++) begin
      if (rdy[u] === 1'b1 && p_rdy[u] !== 1'b1) begin
        if (u == 0) begin
          chk("sb0_nonempty", 32'(sb0.size() != 0), 1);
          if (sb0.size() != 0) begin
            e = sb0.pop_front();
            chk("data0", 32'(data[0]), 32'(e[11:0]));
            chk("err0", 32'(err[0]), 32'(e[12]));
          end
        end else begin
          chk("sb1_nonempty", 32'(sb1.size() != 0), 1);
          if (sb1.size() != 0) begin
            e = sb1.pop_front();
            chk("data1", 32'(data[1]), 32'(e[11:0]));
            chk("err1", 32'(err[1]), 32'(e[12]));
          end
        end
      end
      p_rdy[u] = rdy[u];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int u, input logic [15:0] f);
    logic [12:0] e;
    e = {|f[15:12], f[11:0]};
    if (u == 0) begin
      adc0.push_back(f); sb0.push_back(e);
    end else begin
      adc1.push_back(f); sb1.push_back(e);
    end
  endtask

  // Called at #1 after an edge: request goes high in cycle 0.
  task automatic req_frame(input int u,
                           input logic [15:0] f,
                           input int extra,
                           input int exp_lat);
    int k;
    bit got;
    k = 0;
    got = 0;
    push(u, f);
    req[u] = 1'b1;
    while (k < 300 && !got) begin
      tick();
      k++;
      if (k == 1)
        chk("start", 32'({rdy[u], cs[u]}), 0);
      if (k == 2) req[u] = 1'b0;
      if (k == extra) req[u] = 1'b1;
      if (k == extra + 2) req[u] = 1'b0;
      if (rdy[u] === 1'b1) got = 1;
    end
    chk("rdy_lat", k, exp_lat);
    chk("falls", falls[u], 16);
    chk("cs_hi_done", 32'(cs[u]), 1);
  endtask

  initial begin
    int cf;
    int j;
    int k;
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b0; req[u] = 1'b0; p_rdy[u] = 1'b0;
    end
    repeat (3) tick();
    for (int u = 0; u < 2; u++)
      chk("reset", 32'({rdy[u], data[u], err[u],
                        cs[u], sclk[u]}), 32'h3);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle", 32'({rdy[0], data[0], cs[0], sclk[0]}),
          32'h3);
    end

    req_frame(0, 16'h0A5C, 0, 67);
    repeat (QC + 2) tick();
    req_frame(0, 16'h8FFF, 0, 67);
    repeat (QC + 2) tick();
    req_frame(0, 16'h0001, 0, 67);
    repeat (QC + 2) tick();

    cf = cs_falls[0];
    req_frame(0, 16'h0123, 20, 67);
    repeat (30) tick();
    chk("one_frame", cs_falls[0] - cf, 1);

    req_frame(0, 16'h0456, 0, 67);
    tick();
    push(0, 16'h0BCD);
    req[0] = 1'b1;
    j = 1;
    while (cs[0] !== 1'b0 && j < 50) begin
      tick();
      j++;
      if (j == 3) req[0] = 1'b0;
    end
    chk("pend_gap", j, QC + 1);
    chk("pend_rdy_lo", 32'(rdy[0]), 0);
    k = 1;
    while (rdy[0] !== 1'b1 && k < 300) begin
      tick();
      k++;
    end
    chk("pend_lat", k, 67);
    chk("pend_falls", falls[0], 16);
    repeat (QC + 2) tick();

    req_frame(1, 16'h0ABC, 0, 100);
    repeat (QC + 2) tick();
    adc1.push_back(16'h0777);
    req[1] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 2) req[1] = 1'b0;
    end
    chk("mid_cs", 32'(cs[1]), 0);
    rst_n[1] = 1'b0;
    tick();
    chk("rst_mid", 32'({cs[1], sclk[1], rdy[1], data[1]}),
        32'h6000);
    tick();
    rst_n[1] = 1'b1;
    repeat (5) tick();
    chk("rst_idle", 32'({cs[1], sclk[1], rdy[1]}), 32'h6);
    req_frame(1, 16'h0321, 0, 100);
    repeat (QC + 4) tick();

    chk("sb0_left", sb0.size(), 0);
    chk("sb1_left", sb1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
